// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | inst_fetch_ctrl_if : IF-side handshake and byte-wide RAM port     |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface inst_fetch_ctrl_if;
  logic [31:0] pc_mem;
  logic        pc_valid;
  logic        flush;
  logic        addr_needed;
  logic        inst_available;
  logic [31:0] inst_out;
  logic [31:0] pc_back;
  logic        mem_req;
  logic        mem_grant;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;

  // master: the fetch engine itself
  modport master (
    input  pc_mem, pc_valid, flush, mem_grant, mem_din,
    output addr_needed, inst_available, inst_out, pc_back, mem_req, mem_a
  );

  // slave: the IF stage / arbiter / RAM surrounding the engine
  modport slave (
    output pc_mem, pc_valid, flush, mem_grant, mem_din,
    input  addr_needed, inst_available, inst_out, pc_back, mem_req, mem_a
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | inst_fetch_ctrl : byte-serial 32-bit instruction fetch engine;    |
// | ICACHE_EN adds a direct-mapped instruction cache.  Rev 1.0        |
// +-------------------------------------------------------------------+
module inst_fetch_ctrl #(
  parameter int ICACHE_LINES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] data_q;
  logic [31:0] inst_q;
  logic [31:0] pc_back_q;
  logic [2:0]  issue_q;
  logic [1:0]  rcv_q;
  logic        pend_q;

  logic        req;
  logic        avail;
  logic        issue_fire;
  logic        capture;
  logic        last_byte;
  logic        cache_hit;
  logic [31:0] cache_word;
  logic [31:0] word_d;

  assign req        = (state_q == S_FETCH) && !issue_q[2];
  assign avail      = (state_q == S_DONE) && !bus.flush;
  assign issue_fire = req && bus.mem_grant;
  // A read granted in the cycle of a flush is never captured.
  assign capture    = (state_q == S_FETCH) && pend_q && !bus.flush;
  assign last_byte  = capture && (rcv_q == 2'd3);

  always_comb begin
    word_d = data_q;
    word_d[{rcv_q, 3'b000} +: 8] = bus.mem_din;
  end

  assign bus.addr_needed    = (state_q == S_IDLE) && rst_n;
  assign bus.mem_req        = req;
  assign bus.mem_a          = req ? (pc_q + {29'd0, issue_q}) : 32'd0;
  assign bus.inst_available = avail;
  assign bus.inst_out       = avail ? data_q : inst_q;
  assign bus.pc_back        = avail ? pc_q : pc_back_q;

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] valid_q;
  logic [TAG_W-1:0]        tag_q  [ICACHE_LINES];
  logic [31:0]             line_q [ICACHE_LINES];
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        wr_idx;
  logic                    fill;

  assign rd_idx     = bus.pc_mem[IDX_W+1:2];
  assign wr_idx     = pc_q[IDX_W+1:2];
  assign cache_hit  = (bus.pc_mem[1:0] == 2'b00) && valid_q[rd_idx] &&
                      (tag_q[rd_idx] == bus.pc_mem[31:IDX_W+2]);
  assign cache_word = line_q[rd_idx];
  // Only word-aligned fetches are cacheable.
  assign fill       = last_byte && (pc_q[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[wr_idx]  <= pc_q[31:IDX_W+2];
      line_q[wr_idx] <= word_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (ICACHE_LINES > 0);
  assign cache_hit  = 1'b0;
  assign cache_word = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      data_q    <= 32'd0;
      inst_q    <= 32'd0;
      pc_back_q <= 32'd0;
      issue_q   <= 3'd0;
      rcv_q     <= 2'd0;
      pend_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.pc_valid && !bus.flush) begin
            pc_q    <= bus.pc_mem;
            issue_q <= 3'd0;
            rcv_q   <= 2'd0;
            pend_q  <= 1'b0;
            if (cache_hit) begin
              data_q  <= cache_word;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (bus.flush) begin
            issue_q <= 3'd0;
            rcv_q   <= 2'd0;
            pend_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            pend_q <= issue_fire;
            if (issue_fire) begin
              issue_q <= issue_q + 3'd1;
            end
            if (capture) begin
              data_q <= word_d;
              rcv_q  <= rcv_q + 2'd1;
            end
            if (last_byte) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!bus.flush) begin
            inst_q    <= data_q;
            pc_back_q <= pc_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_inst_fetch_ctrl : randomized bench with a transaction-level    |
// | model of inst_fetch_ctrl (ICACHE_EN aware).  Rev 1.0              |
// +-------------------------------------------------------------------+
module tb_inst_fetch_ctrl;
  localparam int LINES = 32;
`ifdef ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl #(.ICACHE_LINES(LINES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_inst = 32'd0;
  logic [31:0] exp_pc   = 32'd0;
  logic        rd_pend  = 1'b0;
  logic [31:0] rd_addr  = 32'd0;
  bit          cv  [LINES];
  logic [31:0] cpc [LINES];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'hA0;
      32'h0000_1003: return 8'h00;
      default:       return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h6B;
    endcase
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] p);
    return {ram_byte(p + 32'd3), ram_byte(p + 32'd2), ram_byte(p + 32'd1), ram_byte(p)};
  endfunction

  // One clock cycle: drive inputs after the edge, RAM answers the previous grant.
  task automatic step(input logic pv, input logic [31:0] pcm, input logic fl, input logic gnt);
    @(posedge clk);
    #1;
    bus.mem_din   = rd_pend ? ram_byte(rd_addr) : 8'($urandom);
    bus.pc_valid  = pv;
    bus.pc_mem    = pcm;
    bus.flush     = fl;
    bus.mem_grant = gnt;
    @(negedge clk);
    rd_pend = bus.mem_req && bus.mem_grant;
    rd_addr = bus.mem_a;
  endtask

  // fsel: 0 = no flush, >0 = flush in that cycle (clamped), <0 = random choice.
  task automatic run_fetch(input logic [31:0] p, input int gmode, input int fsel);
    bit          gnt [72];
    int          k4, pulse_k, end_k, ng, fk, idx;
    bit          hit, exp_req, exp_av;
    logic [31:0] word;
    for (int k = 0; k < 72; k++) begin
      case (gmode)
        0:       gnt[k] = 1'b1;
        1:       gnt[k] = (k >= 40) || ($urandom_range(0, 3) != 0);
        default: gnt[k] = !(k == 2 || k == 3);
      endcase
    end
    idx  = int'((p >> 2) % LINES);
    hit  = CACHE_ON && (p[1:0] == 2'b00) && cv[idx] && (cpc[idx] == p);
    word = ram_word(p);
    ng = 0;
    k4 = 0;
    for (int k = 1; k < 72; k++) begin
      if (gnt[k]) begin
        ng++;
        if (ng == 4 && k4 == 0) k4 = k;
      end
    end
    pulse_k = hit ? 1 : k4 + 2;
    if (fsel < 0)
      fk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, pulse_k)) : 0;
    else
      fk = (fsel > pulse_k) ? pulse_k : fsel;
    end_k = (fk > 0) ? fk + 1 : pulse_k + 1;

    step(1'b1, p, 1'b0, 1'($urandom));
    chk("accept_addr_needed", bus.addr_needed, 32'd1);
    chk("accept_no_pulse", bus.inst_available, 32'd0);

    ng = 0;
    for (int k = 1; k <= end_k; k++) begin
      step((k < end_k) ? 1'($urandom) : 1'b0, $urandom, (fk == k), gnt[k]);
      exp_req = !hit && (k <= k4) && (k < end_k);
      exp_av  = (k == pulse_k) && (fk != k) && (k < end_k);
      chk("addr_needed", bus.addr_needed, (k == end_k));
      chk("mem_req", bus.mem_req, exp_req);
      if (exp_req) chk("mem_a", bus.mem_a, p + 32'(ng));
      chk("inst_available", bus.inst_available, exp_av);
      if (exp_av) begin
        exp_inst = word;
        exp_pc   = p;
      end
      chk("inst_out", bus.inst_out, exp_inst);
      chk("pc_back", bus.pc_back, exp_pc);
      if (gnt[k] && exp_req) ng++;
    end

    if (CACHE_ON && !hit && (p[1:0] == 2'b00) && (fk == 0 || fk > k4 + 1)) begin
      cv[idx]  = 1'b1;
      cpc[idx] = p;
    end
  endtask

  logic [31:0] pool [4];

  initial begin
    bus.pc_mem    = 32'd0;
    bus.pc_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_grant = 1'b0;
    bus.mem_din   = 8'd0;
    for (int i = 0; i < LINES; i++) cv[i] = 1'b0;
    pool[0] = 32'h0000_1000;
    pool[1] = 32'h0000_1080;
    pool[2] = 32'h0000_2000;
    pool[3] = 32'h0000_0040;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_needed", bus.addr_needed, 32'd0);
    chk("rst_mem_req", bus.mem_req, 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_inst_available", bus.inst_available, 32'd0);
    chk("rst_inst_out", bus.inst_out, 32'd0);
    chk("rst_pc_back", bus.pc_back, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_fetch(32'h0000_1000, 0, 0);
    run_fetch(32'h0000_1000, 2, 0);
    run_fetch(32'h0000_1000, 0, 3);
    run_fetch(32'h0000_2000, 0, 0);
    run_fetch(32'hFFFF_FFFE, 0, 0);
    run_fetch(32'h0000_1080, 0, 0);
    run_fetch(32'h0000_1000, 0, 0);

    // Asynchronous reset in the middle of a fetch.
    step(1'b1, 32'h0000_3000, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_addr_needed", bus.addr_needed, 32'd0);
    chk("midrst_mem_req", bus.mem_req, 32'd0);
    chk("midrst_mem_a", bus.mem_a, 32'd0);
    chk("midrst_inst_available", bus.inst_available, 32'd0);
    chk("midrst_inst_out", bus.inst_out, 32'd0);
    chk("midrst_pc_back", bus.pc_back, 32'd0);
    exp_inst = 32'd0;
    exp_pc   = 32'd0;
    rd_pend  = 1'b0;
    for (int i = 0; i < LINES; i++) cv[i] = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("release_addr_needed", bus.addr_needed, 32'd1);
    chk("release_no_pulse", bus.inst_available, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'd0, 1'b0, 1'b1);
      chk("post_rst_no_pulse", bus.inst_available, 32'd0);
      chk("post_rst_idle", bus.addr_needed, 32'd1);
    end

    for (int t = 0; t < 40; t++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      run_fetch(p, 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Memory-side instruction fetch engine sitting directly upstream of the IF stage. Accepts a fetch address from IF and reads four bytes over the byte-wide RAM port through the memory arbiter. Assembles a little-endian 32-bit instruction and returns it with its PC as a one-cycle `inst_available` pulse. Optional direct-mapped instruction cache serves repeat fetches without touching RAM.

## Interface
Parameters:
- `ICACHE_LINES`, 32, cache entries (power of two; only used with `ICACHE_EN`)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pc_mem`  in  32  fetch address from IF
- `pc_valid`  in  1  IF presents a valid `pc_mem` this cycle (IF not stalled)
- `flush`  in  1  branch interception; abort current fetch
- `addr_needed`  out  1  engine idle, will accept `pc_mem` this cycle
- `inst_available`  out  1  one-cycle pulse, `inst_out`/`pc_back` valid
- `inst_out`  out  32  assembled instruction (to IF `inst_in`)
- `pc_back`  out  32  PC of `inst_out`
- `mem_req`  out  1  request RAM port from arbiter
- `mem_grant`  in  1  arbiter grants RAM port this cycle
- `mem_a`  out  32  RAM byte address
- `mem_din`  in  8  RAM read data, valid the cycle after a granted request

## Operation
- States: IDLE, FETCH, DONE.
- IDLE: `addr_needed`=1. If `pc_valid` && !`flush`: latch `pc_mem` into `pc_q`, clear issue/receive counters, -> FETCH.
- FETCH: `mem_req`=1 while issue count < 4; `mem_a` = `pc_q` + issue count (mod 2^32). Issue count increments only on a cycle with `mem_req` && `mem_grant`. A byte is captured from `mem_din` on the cycle after each granted issue into byte lane = receive count (lane 0 = bits 7:0). After lane 3 captured -> DONE.
- DONE: `inst_available` = !`flush`; `pc_back` = `pc_q`; -> IDLE.
- `flush` high in any state: next state IDLE, counters cleared, partial data discarded, no pulse. An in-flight RAM read is ignored (no capture).
- `pc_valid` ignored outside IDLE.
- `inst_out`/`pc_back` hold last values between pulses.
- Reset (async, any state): state IDLE, all outputs 0 (`addr_needed` held 0 while `rst` low), counters 0, cache valid bits 0.

## Timing
- Accept edge = end of IDLE cycle 0. Continuous grant: issues in cycles 1-4, bytes captured end of cycles 2-5, `inst_available` in cycle 6, `addr_needed` again in cycle 7.
- Each cycle of `mem_grant`=0 during FETCH adds exactly one cycle.
- `flush` asserted in cycle N: no `inst_available` in cycle N; `addr_needed`=1 in cycle N+1.
- `mem_req` drops the cycle after the 4th granted issue.

## Configuration
- `ICACHE_EN` defined: direct-mapped cache of `ICACHE_LINES` 32-bit words; index `pc[log2(ICACHE_LINES)+1:2]`, tag remaining upper bits. On accept in IDLE with hit and `pc_mem[1:0]`==0: -> DONE directly, `inst_available` in cycle 1, no RAM request. Miss: normal FETCH, line filled (valid set) on DONE entry unless flushed. `pc_mem[1:0]`!=0: no lookup, no fill.
- `ICACHE_EN` undefined: no cache storage; every accept performs FETCH.

## Test plan
- Reset then fetch `pc_mem`=0x0000_1000, RAM bytes 0x13,0x05,0xA0,0x00, grant always 1 -> `mem_a` 0x1000..0x1003 in cycles 1-4, `inst_out`=0x00A00513, `pc_back`=0x1000 pulse in cycle 6.
- Same fetch, `mem_grant` low in cycles 2 and 3 -> address 0x1001 repeated held, pulse in cycle 8, same data.
- `flush` in cycle 3 of fetch -> no pulse, `addr_needed`=1 in cycle 4, new fetch at 0x2000 completes normally with correct bytes.
- `pc_mem`=0xFFFF_FFFE -> `mem_a` 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; `pc_back`=0xFFFFFFFE.
- `rst` low during FETCH cycle 3 -> all outputs 0 immediately, no pulse after release, first cycle after release `addr_needed`=1.
- With `ICACHE_EN`: fetch 0x1000 (miss, pulse cycle 6), refetch 0x1000 -> `mem_req` stays 0, pulse cycle 1 with 0x00A00513; fetch 0x1080 (same index, different tag, 32 lines) -> miss, RAM fetch.
